ram_arbiter_mc: RTL and testbench
=================================

# ram_arbiter_mc

Parametrised multi-channel arbiter for the shared dual-port delay RAM in the effects pedal. It sits between NCH effect cores (echo, flanger, chorus, …) and one RAM instance: write port A, synchronous-read port B. Two modes are supported: exclusive ownership chosen by `effects_sel`, or round-robin time-slicing among requesting channels. In exclusive mode the RAM is optionally zero-cleared whenever ownership changes, so a new effect never replays stale samples.

## Interface
Parameters:
- `NCH`, 4: number of client channels (1..6).
- `AW`, 13: RAM address width.
- `DW`, 8: sample width.
- `SELW`, 3: `effects_sel` width.
- `CLR_ON_SWITCH`, 1: when 1, clear the whole RAM on every exclusive-owner change.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `effects_sel` in SELW: 0 = standby; 1..NCH = channel sel-1 owns the RAM; other values are invalid.
- `mode` in 1: 0 = exclusive, 1 = round-robin.
- `req` in NCH: per-channel access request (round-robin mode only).
- `we_a_ch` in NCH: per-channel write enable.
- `dat_a_ch` in NCH*DW: write data; channel i occupies bits [i*DW +: DW].
- `adr_a_ch` in NCH*AW: write addresses, packed the same way.
- `adr_b_ch` in NCH*AW: read addresses, packed the same way.
- `gnt` out NCH: one-hot, registered; marks the channel driving the RAM ports this cycle.
- `dat_b_ch` out NCH*DW: registered read data per channel; holds its value when not updated.
- `dat_b_vld` out NCH: one-cycle strobe per returned read word.
- `status` out 8: 0x00 standby, (1<<sel) exclusive, 0x40 round-robin, 0x80 clearing, 0xD0 invalid `effects_sel`.
- `busy` out 1: high while clearing.
- `adr_a` out AW, `dat_a` out DW, `we_a` out 1, `adr_b` out AW: registered RAM port drives.
- `dat_b` in DW: RAM read data, valid one cycle after `adr_b`.

## Operation
- States: IDLE, OWN, RR, CLEAR, INVAL.
- IDLE (exclusive, sel=0): `gnt`=0, `we_a`=0, `status`=0.
- INVAL (exclusive, sel>NCH): same as IDLE, but `status`=0xD0.
- OWN: owner o=sel-1. `gnt`[o]=1 continuously and `req` is ignored. RAM ports copy channel o's inputs each cycle. Every returned word goes to `dat_b_ch`[o] and strobes `dat_b_vld`[o].
- Owner change in exclusive mode means entry into OWN with o different from the last owner, including the first owner after reset. With CLR_ON_SWITCH=1 this enters CLEAR first.
  - `we_a`=1, `dat_a`=0, `adr_a` steps 0..2^AW-1, one address per cycle.
  - `gnt`=0, `busy`=1, `status`=0x80. Then go to OWN.
  - With CLR_ON_SWITCH=0, go straight to OWN.
- A `sel` or `mode` change during CLEAR aborts the clear and re-evaluates next cycle. A new owner restarts the clear at address 0.
- RR (mode=1, independent of `effects_sel`):
  - Each cycle, grant the first requesting channel after the last granted one, searching index order with wrap-around.
  - If `req`=0, `gnt`=0 and `we_a`=0; the pointer is unchanged.
  - A single requester is granted every cycle.
- `we_a` is only ever asserted for the granted channel's `we_a_ch`, or during CLEAR. Otherwise it is 0.
- Each read is tagged with its granted channel in a 2-stage owner pipeline. Reads still in flight after a mode or sel change are delivered to the tagged channel. A slot with no grant produces no strobe.
- Reset values: every output 0, state IDLE, RR pointer set so channel 0 wins first, owner pipeline cleared, last owner = none. Reset mid-CLEAR or mid-pipeline discards everything and raises no strobes.

## Timing
- Cycle t: inputs sampled (`req`, `*_ch`, `effects_sel`, `mode`).
- Edge t+1: `gnt`, `adr_a`/`dat_a`/`we_a`/`adr_b` registered.
- Edge t+2: RAM presents `dat_b`.
- Edge t+3: `dat_b_ch`[tag] and `dat_b_vld`[tag] registered. Read latency is 3 cycles from request to strobe.
- Writes reach the RAM at edge t+2, 2 cycles after sampling.
- CLEAR takes 2^AW cycles. First owner write lands on the cycle after the last clear address.
- `status` and `busy` are registered and update at the same edge as `gnt`.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs. All outputs are 0; the first strobe appears no earlier than 3 cycles after `rst` falls.
- Exclusive switch with clear (AW=4 for sim): sel 1→2.
  - `busy` high for exactly 16 cycles with addresses 0..15 written as 0, `status`=0x80.
  - Then `status`=0x04 and `gnt`=0010.
  - Subsequent reads of unwritten addresses return 0 on `dat_b_ch`[1].
- Read latency: owner 0, `adr_b_ch`[0]=5 at cycle t with RAM[5]=0xA5. `dat_b_ch`[0]=0xA5 and `dat_b_vld`[0]=1 at edge t+3.
- Round-robin: `req`=1011 held. `gnt` sequence is 0001, 0010, 1000, 0001… Each channel's strobe follows its grant by 2 cycles, and channel 2 never strobes.
- Invalid/standby: sel=7 gives `status`=0xD0, `we_a`=0, `gnt`=0. Then sel=0 gives `status`=0x00. Owner writes during these intervals never reach the RAM.
- Mid-operation events:
  - Toggle `mode` 0→1 during an in-flight owner read. The pending word still strobes on the old owner.
  - Assert `rst` mid-CLEAR. `we_a` is 0 on the next cycle and the clear does not resume.

Source files
------------

// File: rtl/ram_arbiter_mc.sv
// ram_arbiter_mc
// Arbitrates NCH effect cores onto one shared dual-port delay RAM
// (write port A, synchronous-read port B).
//   mode = 0 : exclusive ownership picked by effects_sel
//              (0 = standby, 1..NCH = channel sel-1, other values invalid).
//              When CLR_ON_SWITCH = 1, a change of owner first zero-fills
//              the whole RAM so the new effect never replays stale samples.
//   mode = 1 : round-robin time slicing among channels raising req.
// Ports
//   clk, rst                   : clock, synchronous active-high reset
//   effects_sel, mode, req     : arbitration controls
//   we_a_ch/dat_a_ch/adr_a_ch  : per-channel write port requests (packed)
//   adr_b_ch                   : per-channel read addresses (packed)
//   gnt                        : registered one-hot grant
//   dat_b_ch, dat_b_vld        : registered per-channel read data + strobe
//   status, busy               : registered status byte / clear-in-progress
//   adr_a, dat_a, we_a, adr_b  : registered RAM port drives
//   dat_b                      : RAM read data (one cycle after adr_b)
module ram_arbiter_mc #(
    parameter int NCH           = 4,
    parameter int AW            = 13,
    parameter int DW            = 8,
    parameter int SELW          = 3,
    parameter int CLR_ON_SWITCH = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SELW-1:0]     effects_sel,
    input  logic                mode,
    input  logic [NCH-1:0]      req,
    input  logic [NCH-1:0]      we_a_ch,
    input  logic [NCH*DW-1:0]   dat_a_ch,
    input  logic [NCH*AW-1:0]   adr_a_ch,
    input  logic [NCH*AW-1:0]   adr_b_ch,
    output logic [NCH-1:0]      gnt,
    output logic [NCH*DW-1:0]   dat_b_ch,
    output logic [NCH-1:0]      dat_b_vld,
    output logic [7:0]          status,
    output logic                busy,
    output logic [AW-1:0]       adr_a,
    output logic [DW-1:0]       dat_a,
    output logic                we_a,
    output logic [AW-1:0]       adr_b,
    input  logic [DW-1:0]       dat_b
);

    localparam int OW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OWN   = 3'd1,
        ST_RR    = 3'd2,
        ST_CLEAR = 3'd3,
        ST_INVAL = 3'd4
    } state_e;

    // Registered state and outputs
    state_e              state_q,   state_d;
    logic [NCH-1:0]      gnt_q,     gnt_d;
    logic [7:0]          status_q,  status_d;
    logic                busy_q,    busy_d;
    logic [AW-1:0]       adr_a_q,   adr_a_d;
    logic [DW-1:0]       dat_a_q,   dat_a_d;
    logic                we_a_q,    we_a_d;
    logic [AW-1:0]       adr_b_q,   adr_b_d;
    logic [OW-1:0]       rr_last_q, rr_last_d;
    logic [OW-1:0]       last_own_q, last_own_d;
    logic                last_vld_q, last_vld_d;
    logic [OW-1:0]       clr_own_q, clr_own_d;
    // Owner tag pipeline: stage 1 aligns with adr_b, stage 2 with dat_b
    logic [NCH-1:0]      tag1_q,    tag2_q;
    logic [NCH*DW-1:0]   dat_b_ch_q, dat_b_ch_d;
    logic [NCH-1:0]      dat_b_vld_q;

    // Decoded selection
    logic                sel_zero_s;
    logic                sel_inval_s;
    logic [OW-1:0]       owner_s;
    logic                owner_new_s;
    logic                clr_same_s;
    logic                clr_last_s;
    logic                rr_hit_s;
    logic [OW-1:0]       rr_idx_s;

    // Decode effects_sel and track progress of an ongoing clear
    always_comb begin
        sel_zero_s  = (effects_sel == {SELW{1'b0}});
        sel_inval_s = (effects_sel > SELW'(NCH));
        owner_s     = OW'(effects_sel - SELW'(1));
        owner_new_s = !last_vld_q || (last_own_q != owner_s);
        // Same owner still selected while clearing: keep stepping addresses
        clr_same_s  = (state_q == ST_CLEAR) && (clr_own_q == owner_s);
        clr_last_s  = (adr_a_q == {AW{1'b1}});
    end

    // Round-robin search: first requester after rr_last_q, with wrap-around
    always_comb begin
        rr_hit_s = 1'b0;
        rr_idx_s = rr_last_q;
        for (int j = 0; j < NCH; j++) begin
            if (!rr_hit_s && req[j] && (OW'(j) > rr_last_q)) begin
                rr_hit_s = 1'b1;
                rr_idx_s = OW'(j);
            end else begin
                rr_hit_s = rr_hit_s;
            end
        end
        for (int j = 0; j < NCH; j++) begin
            if (!rr_hit_s && req[j] && (OW'(j) <= rr_last_q)) begin
                rr_hit_s = 1'b1;
                rr_idx_s = OW'(j);
            end else begin
                rr_hit_s = rr_hit_s;
            end
        end
    end

    // Next-state and next-output logic of the arbitration FSM
    always_comb begin
        state_d    = state_q;
        gnt_d      = {NCH{1'b0}};
        status_d   = 8'h00;
        busy_d     = 1'b0;
        adr_a_d    = {AW{1'b0}};
        dat_a_d    = {DW{1'b0}};
        we_a_d     = 1'b0;
        adr_b_d    = {AW{1'b0}};
        rr_last_d  = rr_last_q;
        last_own_d = last_own_q;
        last_vld_d = last_vld_q;
        clr_own_d  = clr_own_q;

        if (mode) begin
            state_d  = ST_RR;
            status_d = 8'h40;
            if (rr_hit_s) begin
                gnt_d[rr_idx_s] = 1'b1;
                we_a_d    = we_a_ch[rr_idx_s];
                adr_a_d   = adr_a_ch[rr_idx_s*AW +: AW];
                dat_a_d   = dat_a_ch[rr_idx_s*DW +: DW];
                adr_b_d   = adr_b_ch[rr_idx_s*AW +: AW];
                rr_last_d = rr_idx_s;
            end else begin
                rr_last_d = rr_last_q;
            end
        end else if (sel_zero_s) begin
            state_d = ST_IDLE;
        end else if (sel_inval_s) begin
            state_d  = ST_INVAL;
            status_d = 8'hD0;
        end else if ((CLR_ON_SWITCH != 0) && owner_new_s && !(clr_same_s && clr_last_s)) begin
            // New owner: zero-fill; a different owner mid-clear restarts at 0
            state_d   = ST_CLEAR;
            clr_own_d = owner_s;
            we_a_d    = 1'b1;
            busy_d    = 1'b1;
            status_d  = 8'h80;
            if (clr_same_s) begin
                adr_a_d = adr_a_q + AW'(1);
            end else begin
                adr_a_d = {AW{1'b0}};
            end
        end else begin
            state_d    = ST_OWN;
            gnt_d[owner_s] = 1'b1;
            we_a_d     = we_a_ch[owner_s];
            adr_a_d    = adr_a_ch[owner_s*AW +: AW];
            dat_a_d    = dat_a_ch[owner_s*DW +: DW];
            adr_b_d    = adr_b_ch[owner_s*AW +: AW];
            status_d   = 8'h01 << effects_sel;
            last_own_d = owner_s;
            last_vld_d = 1'b1;
        end
    end

    // Route returned RAM words to the lane tagged two cycles earlier
    always_comb begin
        dat_b_ch_d = dat_b_ch_q;
        for (int i = 0; i < NCH; i++) begin
            if (tag2_q[i]) begin
                dat_b_ch_d[i*DW +: DW] = dat_b;
            end else begin
                dat_b_ch_d[i*DW +: DW] = dat_b_ch_q[i*DW +: DW];
            end
        end
    end

    // FSM state, registered outputs and owner tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= {NCH{1'b0}};
            status_q    <= 8'h00;
            busy_q      <= 1'b0;
            adr_a_q     <= {AW{1'b0}};
            dat_a_q     <= {DW{1'b0}};
            we_a_q      <= 1'b0;
            adr_b_q     <= {AW{1'b0}};
            rr_last_q   <= OW'(NCH - 1);
            last_own_q  <= {OW{1'b0}};
            last_vld_q  <= 1'b0;
            clr_own_q   <= {OW{1'b0}};
            tag1_q      <= {NCH{1'b0}};
            tag2_q      <= {NCH{1'b0}};
            dat_b_ch_q  <= {(NCH*DW){1'b0}};
            dat_b_vld_q <= {NCH{1'b0}};
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            status_q    <= status_d;
            busy_q      <= busy_d;
            adr_a_q     <= adr_a_d;
            dat_a_q     <= dat_a_d;
            we_a_q      <= we_a_d;
            adr_b_q     <= adr_b_d;
            rr_last_q   <= rr_last_d;
            last_own_q  <= last_own_d;
            last_vld_q  <= last_vld_d;
            clr_own_q   <= clr_own_d;
            tag1_q      <= gnt_d;
            tag2_q      <= tag1_q;
            dat_b_ch_q  <= dat_b_ch_d;
            dat_b_vld_q <= tag2_q;
        end
    end

    assign gnt       = gnt_q;
    assign status    = status_q;
    assign busy      = busy_q;
    assign adr_a     = adr_a_q;
    assign dat_a     = dat_a_q;
    assign we_a      = we_a_q;
    assign adr_b     = adr_b_q;
    assign dat_b_ch  = dat_b_ch_q;
    assign dat_b_vld = dat_b_vld_q;

endmodule

// File: tb/tb_ram_arbiter_mc.sv
// Self-checking bench for ram_arbiter_mc with a small behavioural RAM.
// Reads are predicted from a shadow copy of the RAM and queued with their
// expected channel and arrival cycle; a negedge monitor pops and compares.
module tb_ram_arbiter_mc;

    localparam int NCH  = 4;
    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int SELW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [SELW-1:0]   effects_sel;
    logic              mode;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    we_a_ch;
    logic [NCH*DW-1:0] dat_a_ch;
    logic [NCH*AW-1:0] adr_a_ch;
    logic [NCH*AW-1:0] adr_b_ch;
    logic [NCH-1:0]    gnt;
    logic [NCH*DW-1:0] dat_b_ch;
    logic [NCH-1:0]    dat_b_vld;
    logic [7:0]        status;
    logic              busy;
    logic [AW-1:0]     adr_a;
    logic [DW-1:0]     dat_a;
    logic              we_a;
    logic [AW-1:0]     adr_b;
    logic [DW-1:0]     dat_b;

    ram_arbiter_mc #(.NCH(NCH), .AW(AW), .DW(DW), .SELW(SELW), .CLR_ON_SWITCH(1)) dut (
        .clk(clk), .rst(rst), .effects_sel(effects_sel), .mode(mode), .req(req),
        .we_a_ch(we_a_ch), .dat_a_ch(dat_a_ch), .adr_a_ch(adr_a_ch), .adr_b_ch(adr_b_ch),
        .gnt(gnt), .dat_b_ch(dat_b_ch), .dat_b_vld(dat_b_vld), .status(status), .busy(busy),
        .adr_a(adr_a), .dat_a(dat_a), .we_a(we_a), .adr_b(adr_b), .dat_b(dat_b)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM: write port A, synchronous read port B
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (we_a) mem[adr_a] <= dat_a;
        dat_b <= mem[adr_b];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          ch;
        logic [7:0]  data;
        int          cyc;
    } rd_t;
    rd_t sb[$];

    logic [DW-1:0] sh_mem [2**AW];
    int total = 0;
    int bad   = 0;
    int rr_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest predicted read
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("rd_missing_cyc", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (dat_b_vld != '0) begin
                if (sb.size() == 0) begin
                    chk("rd_extra_vld", {28'd0, dat_b_vld}, 32'd0);
                end else begin
                    rd_t e;
                    e = sb.pop_front();
                    chk("rd_vld_ch", {28'd0, dat_b_vld}, 32'd1 << e.ch);
                    chk("rd_data", {24'd0, dat_b_ch[e.ch*DW +: DW]}, {24'd0, e.data});
                    chk("rd_latency", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic we, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd, input logic [AW-1:0] ra);
        we_a_ch[ch]             = we;
        adr_a_ch[ch*AW +: AW]   = wa;
        dat_a_ch[ch*DW +: DW]   = wd;
        adr_b_ch[ch*AW +: AW]   = ra;
    endtask

    // One sampled cycle with a known expected grant; predicts read and write
    task automatic step(input logic [NCH-1:0] exp_gnt);
        logic exp_we;
        int   ch;
        exp_we = 1'b0;
        ch     = 0;
        for (int i = 0; i < NCH; i++) if (exp_gnt[i]) ch = i;
        if (exp_gnt != '0) begin
            sb.push_back('{ch, sh_mem[adr_b_ch[ch*AW +: AW]], cyc + 3});
            if (we_a_ch[ch]) begin
                sh_mem[adr_a_ch[ch*AW +: AW]] = dat_a_ch[ch*DW +: DW];
                exp_we = 1'b1;
            end
        end
        tick();
        chk("gnt", {28'd0, gnt}, {28'd0, exp_gnt});
        chk("we_a", {31'd0, we_a}, {31'd0, exp_we});
    endtask

    task automatic rr_next(input logic [NCH-1:0] r, output logic [NCH-1:0] g);
        g = '0;
        for (int i = 1; i <= NCH; i++) begin
            int c;
            c = (rr_last + i) % NCH;
            if (g == '0 && r[c]) begin
                g[c]    = 1'b1;
                rr_last = c;
            end
        end
    endtask

    // Select a new exclusive owner and watch the full zero-fill sweep
    task automatic clear_seq(input logic [SELW-1:0] sel);
        effects_sel = sel;
        for (int k = 0; k < 2**AW; k++) begin
            tick();
            chk("clr_busy", {31'd0, busy}, 32'd1);
            chk("clr_status", {24'd0, status}, 32'h80);
            chk("clr_we", {31'd0, we_a}, 32'd1);
            chk("clr_adr", {28'd0, adr_a}, k);
            chk("clr_dat", {24'd0, dat_a}, 32'd0);
            chk("clr_gnt", {28'd0, gnt}, 32'd0);
        end
        for (int a = 0; a < 2**AW; a++) sh_mem[a] = '0;
    endtask

    initial begin
        logic [NCH-1:0] g;
        for (int a = 0; a < 2**AW; a++) begin
            mem[a]    = 8'hE0 | 8'(a);
            sh_mem[a] = 8'hE0 | 8'(a);
        end
        // Reset with random inputs
        rst         = 1'b1;
        mode        = 1'($urandom);
        effects_sel = 3'($urandom);
        req         = 4'($urandom);
        we_a_ch     = 4'($urandom);
        dat_a_ch    = 32'($urandom);
        adr_a_ch    = 16'($urandom);
        adr_b_ch    = 16'($urandom);
        tick();
        tick();
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        chk("rst_status", {24'd0, status}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_we", {31'd0, we_a}, 32'd0);
        chk("rst_adr_a", {28'd0, adr_a}, 32'd0);
        chk("rst_dat_a", {24'd0, dat_a}, 32'd0);
        chk("rst_adr_b", {28'd0, adr_b}, 32'd0);
        chk("rst_vld", {28'd0, dat_b_vld}, 32'd0);
        chk("rst_dat_b_ch", dat_b_ch, 32'd0);
        mode = 1'b0; effects_sel = 3'd0; req = '0; we_a_ch = '0;
        dat_a_ch = '0; adr_a_ch = '0; adr_b_ch = '0;
        rst = 1'b0;
        rr_last = NCH - 1;
        for (int i = 0; i < 3; i++) step('0);
        chk("standby_status", {24'd0, status}, 32'h00);

        // First owner after reset (channel 0) clears the RAM first
        clear_seq(3'd1);
        step(4'b0001);
        chk("own0_status", {24'd0, status}, 32'h02);
        chk("own0_busy", {31'd0, busy}, 32'd0);
        set_ch(0, 1'b1, 4'd5, 8'hA5, 4'd0); step(4'b0001);
        chk("own0_adr_a", {28'd0, adr_a}, 32'd5);
        chk("own0_dat_a", {24'd0, dat_a}, 32'hA5);
        set_ch(0, 1'b1, 4'd3, 8'h3C, 4'd0); step(4'b0001);
        set_ch(0, 1'b0, 4'd0, 8'h00, 4'd5); step(4'b0001);
        chk("own0_adr_b", {28'd0, adr_b}, 32'd5);
        set_ch(0, 1'b0, 4'd0, 8'h00, 4'd3); step(4'b0001);

        // Owner switch 1 -> 2: clear again, old data gone
        clear_seq(3'd2);
        set_ch(1, 1'b0, 4'd0, 8'h00, 4'd5); step(4'b0010);
        chk("own1_status", {24'd0, status}, 32'h04);
        chk("own1_busy", {31'd0, busy}, 32'd0);
        set_ch(1, 1'b0, 4'd0, 8'h00, 4'd3); step(4'b0010);

        // Round-robin, req = 1011; channel 2 wants to write but never wins
        mode = 1'b1; req = 4'b1011;
        set_ch(0, 1'b1, 4'd1, 8'h11, 4'd1);
        set_ch(1, 1'b0, 4'd0, 8'h00, 4'd2);
        set_ch(2, 1'b1, 4'd7, 8'h77, 4'd7);
        set_ch(3, 1'b0, 4'd0, 8'h00, 4'd4);
        for (int i = 0; i < 8; i++) begin
            rr_next(req, g);
            step(g);
            chk("rr_status", {24'd0, status}, 32'h40);
        end
        req = 4'b0000;
        for (int i = 0; i < 2; i++) begin rr_next(req, g); step(g); end
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin rr_next(req, g); step(g); end
        req = 4'b1011; we_a_ch = '0;
        for (int i = 0; i < 3; i++) begin rr_next(req, g); step(g); end

        // Invalid select then standby; owner writes must not land
        mode = 1'b0; effects_sel = 3'd7;
        for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, 4'd9, 8'h99, 4'd0);
        for (int i = 0; i < 3; i++) step('0);
        chk("inval_status", {24'd0, status}, 32'hD0);
        chk("inval_busy", {31'd0, busy}, 32'd0);
        effects_sel = 3'd0;
        for (int i = 0; i < 2; i++) step('0);
        chk("idle_status", {24'd0, status}, 32'h00);
        we_a_ch = '0;

        // Back to the same owner (channel 1): no clear needed
        effects_sel = 3'd2;
        set_ch(1, 1'b0, 4'd0, 8'h00, 4'd9); step(4'b0010);
        chk("reown_status", {24'd0, status}, 32'h04);
        chk("reown_busy", {31'd0, busy}, 32'd0);
        set_ch(1, 1'b0, 4'd0, 8'h00, 4'd7); step(4'b0010);
        set_ch(1, 1'b0, 4'd0, 8'h00, 4'd1); step(4'b0010);

        // Mode flips to round-robin with owner reads still in flight
        mode = 1'b1; req = '0;
        for (int i = 0; i < 3; i++) begin rr_next(req, g); step(g); end
        chk("flight_drained", sb.size(), 32'd0);

        // Reset in the middle of a clear
        mode = 1'b0; effects_sel = 3'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_clr_we", {31'd0, we_a}, 32'd1);
            chk("mid_clr_adr", {28'd0, adr_a}, i);
        end
        rst = 1'b1; effects_sel = 3'd0;
        tick();
        chk("rst_clr_we", {31'd0, we_a}, 32'd0);
        chk("rst_clr_busy", {31'd0, busy}, 32'd0);
        chk("rst_clr_status", {24'd0, status}, 32'd0);
        tick();
        rst = 1'b0;
        rr_last = NCH - 1;
        for (int i = 0; i < 4; i++) begin
            step('0);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        // The interrupted clear is restarted from address 0, not resumed
        clear_seq(3'd3);
        set_ch(2, 1'b0, 4'd0, 8'h00, 4'd7); step(4'b0100);
        chk("own2_status", {24'd0, status}, 32'h08);
        for (int i = 0; i < 4; i++) step(4'b0100);
        effects_sel = 3'd0;
        for (int i = 0; i < 4; i++) step('0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
